axi4_reg_slice: RTL and testbench

- Parametrised AXI4 register slice: one independent pipeline stage on each of the five AXI4 channels (AW, W, B, AR, R).
- Breaks timing paths between an upstream master and a downstream slave.
- Address, data and ID widths are generalised, and each channel has a selectable buffering mode.
- Placed between interconnect segments, or at subsystem boundaries, on buses that use the team's axi4_ace_if.

---
 rtl/axi4_reg_slice_pkg.sv | 35 +++
 rtl/axi4_ace_if.sv | 76 +++++++
 rtl/axi4_reg_slice_chan.sv | 130 +++++++++++++
 rtl/axi4_reg_slice.sv | 89 ++++++++
 tb/tb_axi4_reg_slice.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_reg_slice_pkg.sv
// Shared types and payload-width helpers for the AXI4 register slice.
package axi4_reg_slice_pkg;

  typedef enum int {
    MODE_BYPASS = 0,
    MODE_FWD    = 1,
    MODE_FULL   = 2
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fill_e;

  // len(8)+size(3)+burst(2)+lock(1)+cache(4)+prot(3)+qos(4)+region(4)
  localparam int AX_FIXED_W = 29;

  function automatic int ax_width(input int addr_w, input int id_w);
    return id_w + addr_w + AX_FIXED_W;
  endfunction

  function automatic int w_width(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int b_width(input int id_w);
    return id_w + 2;
  endfunction

  function automatic int r_width(input int data_w, input int id_w);
    return id_w + data_w + 3;
  endfunction

endpackage

// File: rtl/axi4_ace_if.sv
// AXI4 bus bundle with master/slave modports.
interface axi4_ace_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 128,
  parameter int AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]      awid;
  logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awlock;
  logic [3:0]                    awcache;
  logic [2:0]                    awprot;
  logic [3:0]                    awqos;
  logic [3:0]                    awregion;
  logic                          awvalid;
  logic                          awready;

  logic [AXI4_DATA_WIDTH-1:0]    wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]  wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  logic [AXI4_ID_WIDTH-1:0]      bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [AXI4_ID_WIDTH-1:0]      arid;
  logic [AXI4_ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arlock;
  logic [3:0]                    arcache;
  logic [2:0]                    arprot;
  logic [3:0]                    arqos;
  logic [3:0]                    arregion;
  logic                          arvalid;
  logic                          arready;

  logic [AXI4_ID_WIDTH-1:0]      rid;
  logic [AXI4_DATA_WIDTH-1:0]    rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_reg_slice_chan.sv
// One valid/ready pipeline stage: MODE 0 bypass (0 cycles), 1 forward (1 cycle), 2 full skid (1 cycle).
// Backpressure: bypass passes ready through, forward ready = !dst_vld || dst_rdy, full ready is a flop.
module axi4_reg_slice_chan
  import axi4_reg_slice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             src_vld,
  output logic             src_rdy,
  input  logic [WIDTH-1:0] src_dat,
  output logic             dst_vld,
  input  logic             dst_rdy,
  output logic [WIDTH-1:0] dst_dat,
  output logic             proto_err
);

  generate
    if (MODE == int'(MODE_BYPASS)) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk ^ rstn;
      assign dst_vld    = src_vld;
      assign dst_dat    = src_dat;
      assign src_rdy    = dst_rdy;
    end else if (MODE == int'(MODE_FWD)) begin : g_fwd
      logic             vld_q;
      logic [WIDTH-1:0] dat_q;

      assign src_rdy = !vld_q || dst_rdy;
      assign dst_vld = vld_q;
      assign dst_dat = dat_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (src_rdy) begin
          vld_q <= src_vld;
          if (src_vld) dat_q <= src_dat;
        end
      end
    end else if (MODE == int'(MODE_FULL)) begin : g_full
      fill_e            state_q, state_d;
      logic             rdy_q;
      logic [WIDTH-1:0] main_q, skid_q;
      logic             acc, take;

      assign acc  = src_vld && rdy_q;
      assign take = dst_vld && dst_rdy;

      // Ready is registered from the next state so neither side sees a combinational path.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_q <= ST_EMPTY;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != ST_TWO);
        end
      end

      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_EMPTY: if (acc) state_d = ST_ONE;
          ST_ONE: begin
            if (acc && !take)      state_d = ST_TWO;
            else if (!acc && take) state_d = ST_EMPTY;
          end
          ST_TWO:   if (take) state_d = ST_ONE;
          default:  state_d = ST_EMPTY;
        endcase
      end

      always_comb begin
        dst_vld = (state_q != ST_EMPTY);
        src_rdy = rdy_q;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          main_q <= '0;
          skid_q <= '0;
        end else if (state_q == ST_TWO) begin
          if (take) main_q <= skid_q;
        end else if (acc) begin
          if (state_q == ST_EMPTY || take) main_q <= src_dat;
          else                             skid_q <= src_dat;
        end
      end

      assign dst_dat = main_q;
    end else begin : g_bad
      $fatal(1, "axi4_reg_slice_chan: unsupported MODE %0d", MODE);
    end
  endgenerate

`ifdef AXI4_REG_SLICE_CHECK_EN
  logic             prev_vld_q, prev_rdy_q, err_q, viol;
  logic [WIDTH-1:0] prev_dat_q;

  // A beat offered but not taken must stay valid and stable.
  assign viol = prev_vld_q && !prev_rdy_q && (!src_vld || (src_dat != prev_dat_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_vld_q <= 1'b0;
      prev_rdy_q <= 1'b0;
      prev_dat_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_vld_q <= src_vld;
      prev_rdy_q <= src_rdy;
      prev_dat_q <= src_dat;
      if (viol) err_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rstn && viol && !err_q) $error("axi4_reg_slice_chan: src handshake violation");
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: one independent stage per channel (AW/W/AR s->m, B/R m->s); packs payloads only.
// Optional upstream handshake checker enabled by macro AXI4_REG_SLICE_CHECK_EN.
module axi4_reg_slice
  import axi4_reg_slice_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 128,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int AW_MODE            = 2,
  parameter int W_MODE             = 2,
  parameter int B_MODE             = 2,
  parameter int AR_MODE            = 2,
  parameter int R_MODE             = 2
) (
  input  logic       clk,
  input  logic       rstn,
  axi4_ace_if.slave  s,
  axi4_ace_if.master m,
  output logic       proto_err
);

  localparam int AXW = ax_width(AXI4_ADDRESS_WIDTH, AXI4_ID_WIDTH);
  localparam int WW  = w_width(AXI4_DATA_WIDTH);
  localparam int BW  = b_width(AXI4_ID_WIDTH);
  localparam int RW  = r_width(AXI4_DATA_WIDTH, AXI4_ID_WIDTH);

  logic [AXW-1:0] aw_src, aw_dst, ar_src, ar_dst;
  logic [WW-1:0]  w_src, w_dst;
  logic [BW-1:0]  b_src, b_dst;
  logic [RW-1:0]  r_src, r_dst;
  logic [4:0]     chan_err;

  assign aw_src = {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst, s.awlock,
                   s.awcache, s.awprot, s.awqos, s.awregion};
  assign {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst, m.awlock,
          m.awcache, m.awprot, m.awqos, m.awregion} = aw_dst;

  assign w_src = {s.wdata, s.wstrb, s.wlast};
  assign {m.wdata, m.wstrb, m.wlast} = w_dst;

  assign b_src = {m.bid, m.bresp};
  assign {s.bid, s.bresp} = b_dst;

  assign ar_src = {s.arid, s.araddr, s.arlen, s.arsize, s.arburst, s.arlock,
                   s.arcache, s.arprot, s.arqos, s.arregion};
  assign {m.arid, m.araddr, m.arlen, m.arsize, m.arburst, m.arlock,
          m.arcache, m.arprot, m.arqos, m.arregion} = ar_dst;

  assign r_src = {m.rid, m.rdata, m.rresp, m.rlast};
  assign {s.rid, s.rdata, s.rresp, s.rlast} = r_dst;

  axi4_reg_slice_chan #(.WIDTH(AXW), .MODE(AW_MODE)) u_aw (
    .clk(clk), .rstn(rstn),
    .src_vld(s.awvalid), .src_rdy(s.awready), .src_dat(aw_src),
    .dst_vld(m.awvalid), .dst_rdy(m.awready), .dst_dat(aw_dst),
    .proto_err(chan_err[0])
  );

  axi4_reg_slice_chan #(.WIDTH(WW), .MODE(W_MODE)) u_w (
    .clk(clk), .rstn(rstn),
    .src_vld(s.wvalid), .src_rdy(s.wready), .src_dat(w_src),
    .dst_vld(m.wvalid), .dst_rdy(m.wready), .dst_dat(w_dst),
    .proto_err(chan_err[1])
  );

  axi4_reg_slice_chan #(.WIDTH(BW), .MODE(B_MODE)) u_b (
    .clk(clk), .rstn(rstn),
    .src_vld(m.bvalid), .src_rdy(m.bready), .src_dat(b_src),
    .dst_vld(s.bvalid), .dst_rdy(s.bready), .dst_dat(b_dst),
    .proto_err(chan_err[2])
  );

  axi4_reg_slice_chan #(.WIDTH(AXW), .MODE(AR_MODE)) u_ar (
    .clk(clk), .rstn(rstn),
    .src_vld(s.arvalid), .src_rdy(s.arready), .src_dat(ar_src),
    .dst_vld(m.arvalid), .dst_rdy(m.arready), .dst_dat(ar_dst),
    .proto_err(chan_err[3])
  );

  axi4_reg_slice_chan #(.WIDTH(RW), .MODE(R_MODE)) u_r (
    .clk(clk), .rstn(rstn),
    .src_vld(m.rvalid), .src_rdy(m.rready), .src_dat(r_src),
    .dst_vld(s.rvalid), .dst_rdy(s.rready), .dst_dat(r_dst),
    .proto_err(chan_err[4])
  );

  assign proto_err = |chan_err;

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Scoreboard bench for axi4_reg_slice: AW/W/AR full, B bypass, R forward.
module tb_axi4_reg_slice;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
`ifdef AXI4_REG_SLICE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic proto_err;
  always #5 clk = ~clk;

  axi4_ace_if #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) s_if ();
  axi4_ace_if #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) m_if ();

  axi4_reg_slice #(
    .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
    .AW_MODE(2), .W_MODE(2), .B_MODE(0), .AR_MODE(2), .R_MODE(1)
  ) dut (
    .clk(clk), .rstn(rstn), .s(s_if), .m(m_if), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc, acc0;
  int r_outs   = 0;
  logic r_model_vld;
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$], exp_r[$];
  logic [5:0]  exp_b[$];
  int aw_out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Output monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_if.awvalid && m_if.awready) begin
        aw_out_cyc.push_back(cyc);
        if (exp_aw.size() == 0) fail("aw_unexpected", "beat with empty scoreboard");
        else chk("aw_addr", m_if.awaddr, exp_aw.pop_front());
      end
      if (m_if.wvalid && m_if.wready) begin
        if (exp_w.size() == 0) fail("w_unexpected", "beat with empty scoreboard");
        else chk("w_data", m_if.wdata, exp_w.pop_front());
      end
      if (m_if.arvalid && m_if.arready) begin
        if (exp_ar.size() == 0) fail("ar_unexpected", "beat with empty scoreboard");
        else chk("ar_addr", m_if.araddr, exp_ar.pop_front());
      end
      if (s_if.rvalid && s_if.rready) begin
        r_outs++;
        if (exp_r.size() == 0) fail("r_unexpected", "beat with empty scoreboard");
        else chk("r_data", s_if.rdata, exp_r.pop_front());
      end
      if (s_if.bvalid && s_if.bready) begin
        if (exp_b.size() == 0) fail("b_unexpected", "beat with empty scoreboard");
        else chk("b_id_resp", {s_if.bid, s_if.bresp}, exp_b.pop_front());
      end
    end
  end

  task automatic aw_beat(input logic [31:0] addr, output int acc_cyc);
    s_if.awvalid = 1'b1; s_if.awaddr = addr; s_if.awid = addr[7:4];
    acc_cyc = -1;
    for (int k = 0; k < 64 && acc_cyc < 0; k++) begin
      @(negedge clk);
      if (s_if.awready) acc_cyc = cyc;
    end
    if (acc_cyc < 0) fail("aw_accept_timeout", "awready never rose");
    else exp_aw.push_back(addr);
    @(posedge clk); #1;
  endtask

  task automatic w_beat(input logic [31:0] data);
    bit ok = 0;
    s_if.wvalid = 1'b1; s_if.wdata = data; s_if.wstrb = '1; s_if.wlast = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = s_if.wready;
    end
    if (!ok) fail("w_accept_timeout", "wready never rose");
    else exp_w.push_back(data);
    @(posedge clk); #1;
  endtask

  task automatic ar_beat(input logic [31:0] addr);
    bit ok = 0;
    s_if.arvalid = 1'b1; s_if.araddr = addr; s_if.arid = addr[11:8];
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = s_if.arready;
    end
    if (!ok) fail("ar_accept_timeout", "arready never rose");
    else exp_ar.push_back(addr);
    @(posedge clk); #1;
  endtask

  task automatic r_beat(input logic [31:0] data);
    bit ok = 0;
    m_if.rvalid = 1'b1; m_if.rdata = data; m_if.rid = data[3:0]; m_if.rresp = 2'b00; m_if.rlast = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = m_if.rready;
    end
    if (!ok) fail("r_accept_timeout", "rready never rose");
    else exp_r.push_back(data);
    @(posedge clk); #1;
  endtask

  initial begin
    s_if.awvalid = 0; s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0;
    s_if.awburst = '0; s_if.awlock = 0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0;
    s_if.awregion = '0;
    s_if.wvalid = 0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 0;
    s_if.arvalid = 0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
    s_if.arburst = '0; s_if.arlock = 0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0;
    s_if.arregion = '0;
    s_if.bready = 1; s_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bvalid = 0; m_if.bid = '0; m_if.bresp = '0;
    m_if.rvalid = 0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;

    // Reset state
    #12;
    chk("rst_m_awvalid", m_if.awvalid, 0);
    chk("rst_s_awready", s_if.awready, 1);
    chk("rst_m_awaddr", m_if.awaddr, 0);
    chk("rst_m_wvalid", m_if.wvalid, 0);
    chk("rst_s_wready", s_if.wready, 1);
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_s_arready", s_if.arready, 1);
    chk("rst_s_rvalid", s_if.rvalid, 0);
    chk("rst_m_rready", m_if.rready, 1);
    chk("rst_proto_err", proto_err, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Streaming: 16 back-to-back AW beats, one cycle latency, no bubbles
    aw_out_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      aw_beat(32'h1000 + i * 16, acc);
      if (i == 0) acc0 = acc;
    end
    s_if.awvalid = 0;
    repeat (3) @(posedge clk); #1;
    chk("aw_stream_count", aw_out_cyc.size(), 16);
    for (int i = 0; i < 16 && i < aw_out_cyc.size(); i++)
      chk($sformatf("aw_stream_cyc%0d", i), aw_out_cyc[i], acc0 + 1 + i);

    // Backpressure on W: two beats fill main+skid, third is held
    m_if.wready = 0;
    w_beat(32'hA1);
    w_beat(32'hA2);
    chk("w_rdy_after_two", s_if.wready, 0);
    s_if.wvalid = 1; s_if.wdata = 32'hA3;
    repeat (3) begin
      @(negedge clk);
      chk("w_held_rdy", s_if.wready, 0);
      chk("w_held_vld", m_if.wvalid, 1);
      chk("w_held_dat", m_if.wdata, 32'hA1);
    end
    @(posedge clk); #1;
    m_if.wready = 1;
    w_beat(32'hA3);
    s_if.wvalid = 0;
    repeat (4) @(posedge clk); #1;
    chk("w_drained", exp_w.size(), 0);

    // Forward mode on R with toggling downstream ready
    r_model_vld = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) r_beat(i);
        m_if.rvalid = 0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          s_if.rready = (k % 2 == 0);
          @(negedge clk);
          chk("r_fwd_vld", s_if.rvalid, r_model_vld);
          chk("r_fwd_rdy", m_if.rready, !r_model_vld || s_if.rready);
          if (!r_model_vld || s_if.rready) r_model_vld = m_if.rvalid;
          @(posedge clk); #1;
        end
      end
    join
    s_if.rready = 1;
    repeat (3) @(posedge clk); #1;
    chk("r_drained", exp_r.size(), 0);
    chk("r_out_count", r_outs, 4);

    // Bypass mode on B: same-cycle payload, ready passes straight through
    s_if.bready = 0;
    m_if.bvalid = 1; m_if.bid = 4'h5; m_if.bresp = 2'b10;
    #1;
    chk("b_byp_vld", s_if.bvalid, 1);
    chk("b_byp_id", s_if.bid, 4'h5);
    chk("b_byp_resp", s_if.bresp, 2'b10);
    chk("b_byp_rdy_lo", m_if.bready, 0);
    exp_b.push_back(6'b0101_10);
    s_if.bready = 1;
    #1;
    chk("b_byp_rdy_hi", m_if.bready, 1);
    @(posedge clk); #1;
    m_if.bvalid = 0;
    chk("b_drained", exp_b.size(), 0);

    // Reset with AR holding two beats
    m_if.arready = 0;
    ar_beat(32'h200);
    ar_beat(32'h300);
    s_if.arvalid = 0;
    chk("ar_two_rdy", s_if.arready, 0);
    chk("ar_two_vld", m_if.arvalid, 1);
    chk("ar_two_addr", m_if.araddr, 32'h200);
    #1 rstn = 0;
    #1;
    chk("ar_rst_vld", m_if.arvalid, 0);
    chk("ar_rst_rdy", s_if.arready, 1);
    chk("ar_rst_addr", m_if.araddr, 0);
    exp_ar.delete();
    #1 rstn = 1;
    m_if.arready = 1;
    repeat (5) @(posedge clk); #1;
    ar_beat(32'h400);
    s_if.arvalid = 0;
    repeat (3) @(posedge clk); #1;
    chk("ar_post_rst_drained", exp_ar.size(), 0);

    // Payload change while AW is stalled
    m_if.awready = 0;
    aw_beat(32'h10, acc);
    aw_beat(32'h20, acc);
    s_if.awvalid = 1; s_if.awaddr = 32'h30; s_if.awid = 4'h3;
    @(posedge clk); #1;
    chk("err_legal_hold", proto_err, 0);
    s_if.awaddr = 32'h34;
    @(posedge clk); #1;
    chk("err_set", proto_err, EXP_ERR);
    repeat (3) @(posedge clk); #1;
    chk("err_held", proto_err, EXP_ERR);
    m_if.awready = 1;
    aw_beat(32'h34, acc);
    s_if.awvalid = 0;
    repeat (4) @(posedge clk); #1;
    chk("aw_final_drained", exp_aw.size(), 0);
    chk("err_held_end", proto_err, EXP_ERR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
